bsg_wormhole_traffic_gen: RTL and testbench
===========================================

BSG_WORMHOLE_TRAFFIC_GEN -- requirements
Module: bsg_wormhole_traffic_gen

Interface
REQ-001 SHALL have parameter width_p, default 32, flit width in bits.
REQ-002 SHALL have parameter x_cord_width_p, default 4, header X-coordinate field width.
REQ-003 SHALL have parameter y_cord_width_p, default 4, header Y-coordinate field width.
REQ-004 SHALL have parameter len_width_p, default 4, header length field width.
REQ-005 SHALL have parameter reserved_width_p, default 0, reserved header field width, driven zero.
REQ-006 SHALL have parameter header_on_lsb_p, default 0: 0 packs fields reserved,X,Y,len from MSB downward; 1 packs them from bit 0 upward.
REQ-007 SHALL have parameter num_dests_p, default 4, destination table entries (>=1).
REQ-008 SHALL have parameter count_width_p, default 16, packet counter width.
REQ-009 SHALL have ports: clk_i  in  1  clock; reset_n_i  in  1  reset.
REQ-010 SHALL implement one clock; reset is asynchronous and active-low.
REQ-011 SHALL have ports: dest_x_i  in  num_dests_p*x_cord_width_p  X table (entry i at slice i); dest_y_i  in  num_dests_p*y_cord_width_p  Y table.
REQ-012 SHALL have ports: len_i  in  len_width_p  body flits per packet; mode_i  in  1  payload mode; num_packets_i  in  count_width_p  packet budget (0 = unlimited); enable_i  in  1  run.
REQ-013 SHALL have ports: valid_o  out  1; data_o  out  width_p; ready_i  in  1; done_o  out  1  budget reached; packets_sent_o  out  count_width_p  completed packets.

Function
REQ-014 SHALL source flits through an internal two-entry FIFO; valid_o/data_o are FIFO outputs; a flit transfers when valid_o & ready_i; data_o holds stable while valid_o & ~ready_i.
REQ-015 SHALL run FSM IDLE, HEADER, BODY, DONE; reset state IDLE.
REQ-016 IDLE: enable_i=1 & done condition false -> HEADER next cycle; otherwise stay.
REQ-017 HEADER: offer header flit; on FIFO accept latch len_i into len_r and mode_i into mode_r; len_i=0 -> packet complete, go IDLE; else load body counter = len_i-1, go BODY.
REQ-018 Header flit SHALL carry dest table entry dest_idx_r in X/Y fields, len_i in len field, all other bits zero.
REQ-019 BODY: offer one flit per cycle while FIFO ready; after accepting flit with counter 0 -> packet complete, go IDLE; else decrement counter.
REQ-020 mode_r=0: body flit = body counter value zero-extended to width_p (descending len-1..0).
REQ-021 mode_r=1: body flit = seq_r, a width_p free-running count incremented per accepted body flit, wrapping modulo 2^width_p, cleared only by reset.
REQ-022 Packet complete SHALL increment packets_sent_o (wraps modulo 2^count_width_p) and advance dest_idx_r by 1, wrapping num_dests_p-1 -> 0.
REQ-023 enable_i SHALL be sampled only in IDLE; deassertion mid-packet does not truncate the packet.
REQ-024 Done condition: num_packets_i != 0 & packets_sent_o == num_packets_i; in IDLE this SHALL move FSM to DONE.
REQ-025 DONE: done_o=1; enable_i=0 -> clear packets_sent_o, go IDLE; else stay. done_o=0 in all other states.
REQ-026 Changes to len_i/mode_i during a packet SHALL not affect it; dest table sampled at header offer.
REQ-027 Latency: header enqueued in HEADER cycle appears on valid_o the following cycle; with ready_i held 1, throughput is one flit per cycle including back-to-back packets (one IDLE cycle between packets permitted).

Reset
REQ-028 reset_n_i low SHALL immediately force state IDLE, FIFO empty, valid_o=0, done_o=0, packets_sent_o=0, dest_idx_r=0, seq_r=0, counter 0, independent of clk_i.
REQ-029 Reset asserted mid-packet SHALL discard partial packet; after release the next packet starts with a header to dest entry 0.

Verification
REQ-030 len_i=3, mode_i=0, ready_i=1, num_packets_i=1, enable_i=1 -> header(dest 0, len 3), then 2,1,0; packets_sent_o=1; done_o=1.
REQ-031 num_dests_p=4, len_i=0, num_packets_i=6 -> six header-only flits to entries 0,1,2,3,0,1; done_o=1; drop enable_i -> packets_sent_o=0, IDLE.
REQ-032 mode_i=1, len_i=2, three packets -> body payloads 0,1,2,3,4,5 across packets.
REQ-033 ready_i toggled randomly, len_i=15 -> no flit lost/duplicated, data_o stable while stalled, order preserved.
REQ-034 reset_n_i pulsed low mid-BODY (between clock edges) -> valid_o drops immediately; next packet header targets entry 0, packets_sent_o=0.

Source files
------------

// File: rtl/bsg_wormhole_traffic_gen_if.sv
// Valid/ready flit link between the traffic generator and its consumer.
//   valid_o : generator has a flit on data_o
//   data_o  : flit payload, width_p bits
//   ready_i : consumer accepts the flit this cycle
// master = generator side, slave = consumer side.
interface bsg_wormhole_traffic_gen_if #(
  parameter int width_p = 32
);
  logic               valid_o;
  logic [width_p-1:0] data_o;
  logic               ready_i;

  modport master (output valid_o, output data_o, input ready_i);
  modport slave  (input valid_o, input data_o, output ready_i);
endinterface

// File: rtl/bsg_wormhole_traffic_gen.sv
// Wormhole packet traffic generator.
// Emits packets made of one header flit (destination X/Y plus body length)
// followed by len body flits. Destinations rotate through a fixed table.
// Body payload is either a per-packet countdown or a global sequence number.
// Ports:
//   clk_i, reset_n_i    : clock, asynchronous active-low reset
//   dest_x_i, dest_y_i  : destination table, entry i at slice i
//   len_i               : body flits per packet
//   mode_i              : 0 = countdown payload, 1 = sequence payload
//   num_packets_i       : packet budget, 0 = unlimited
//   enable_i            : run request, sampled between packets
//   out_if              : valid/ready flit output (two-entry FIFO output)
//   done_o              : budget reached, held until enable_i drops
//   packets_sent_o      : completed packets
//
// state  | meaning
// IDLE   | between packets; checks budget and enable_i
// HEADER | offering header flit to the FIFO
// BODY   | offering body flits, counter counts down to 0
// DONE   | budget reached; waits for enable_i low to clear count
module bsg_wormhole_traffic_gen #(
  parameter int width_p          = 32,
  parameter int x_cord_width_p   = 4,
  parameter int y_cord_width_p   = 4,
  parameter int len_width_p      = 4,
  parameter int reserved_width_p = 0,
  parameter int header_on_lsb_p  = 0,
  parameter int num_dests_p      = 4,
  parameter int count_width_p    = 16
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic [num_dests_p*x_cord_width_p-1:0]  dest_x_i,
  input  logic [num_dests_p*y_cord_width_p-1:0]  dest_y_i,
  input  logic [len_width_p-1:0]                 len_i,
  input  logic                                   mode_i,
  input  logic [count_width_p-1:0]               num_packets_i,
  input  logic                                   enable_i,
  bsg_wormhole_traffic_gen_if.master             out_if,
  output logic                                   done_o,
  output logic [count_width_p-1:0]               packets_sent_o
);

  localparam int idx_w_lp = (num_dests_p > 1) ? $clog2(num_dests_p) : 1;
  localparam int hdr_w_lp = reserved_width_p + x_cord_width_p
                          + y_cord_width_p + len_width_p;

  // Field bit positions. MSB packing puts reserved on top, then X, Y, len;
  // LSB packing puts reserved at bit 0, then X, Y, len going upward.
  localparam int x_lsb_lp   = (header_on_lsb_p != 0) ? reserved_width_p
                            : width_p - reserved_width_p - x_cord_width_p;
  localparam int y_lsb_lp   = (header_on_lsb_p != 0) ? reserved_width_p + x_cord_width_p
                            : width_p - reserved_width_p - x_cord_width_p - y_cord_width_p;
  localparam int len_lsb_lp = (header_on_lsb_p != 0)
                            ? reserved_width_p + x_cord_width_p + y_cord_width_p
                            : width_p - hdr_w_lp;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    BODY   = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic [len_width_p-1:0]   cnt_q, cnt_d;
  logic                     mode_q, mode_d;
  logic [width_p-1:0]       seq_q, seq_d;
  logic [idx_w_lp-1:0]      dest_idx_q, dest_idx_d;
  logic [count_width_p-1:0] sent_q, sent_d;

  logic                     enq_v;
  logic [width_p-1:0]       enq_data;
  logic                     pkt_done;
  logic                     clr_sent;
  logic                     done_cond;

  // Two-entry output FIFO
  logic [width_p-1:0]       mem_q [2];
  logic                     wr_ptr_q, rd_ptr_q;
  logic [1:0]               fifo_cnt_q;
  logic                     fifo_ready;
  logic                     enq, deq;

  logic [x_cord_width_p-1:0] dest_x_sel;
  logic [y_cord_width_p-1:0] dest_y_sel;
  logic [width_p-1:0]        header_flit;

  assign dest_x_sel = dest_x_i[dest_idx_q*x_cord_width_p +: x_cord_width_p];
  assign dest_y_sel = dest_y_i[dest_idx_q*y_cord_width_p +: y_cord_width_p];

  // Reserved bits and everything outside the header fields stay zero.
  assign header_flit = (width_p'(dest_x_sel) << x_lsb_lp)
                     | (width_p'(dest_y_sel) << y_lsb_lp)
                     | (width_p'(len_i)      << len_lsb_lp);

  assign done_cond = (num_packets_i != '0) && (sent_q == num_packets_i);

  assign fifo_ready     = (fifo_cnt_q != 2'd2);
  assign enq            = enq_v & fifo_ready;
  assign out_if.valid_o = (fifo_cnt_q != 2'd0);
  assign out_if.data_o  = mem_q[rd_ptr_q];
  assign deq            = out_if.valid_o & out_if.ready_i;

  assign packets_sent_o = sent_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    seq_d    = seq_q;
    enq_v    = 1'b0;
    enq_data = '0;
    pkt_done = 1'b0;
    clr_sent = 1'b0;
    done_o   = 1'b0;

    case (state_q)
      IDLE: begin
        if (done_cond)     state_d = DONE;
        else if (enable_i) state_d = HEADER;
      end

      HEADER: begin
        enq_v    = 1'b1;
        enq_data = header_flit;
        if (fifo_ready) begin
          // The counter captures len_i here, so later len_i changes are ignored.
          mode_d = mode_i;
          if (len_i == '0) begin
            pkt_done = 1'b1;
            state_d  = IDLE;
          end else begin
            cnt_d   = len_i - len_width_p'(1);
            state_d = BODY;
          end
        end
      end

      BODY: begin
        enq_v    = 1'b1;
        enq_data = mode_q ? seq_q : width_p'(cnt_q);
        if (fifo_ready) begin
          if (mode_q) seq_d = seq_q + width_p'(1);
          if (cnt_q == '0) begin
            pkt_done = 1'b1;
            state_d  = IDLE;
          end else begin
            cnt_d = cnt_q - len_width_p'(1);
          end
        end
      end

      DONE: begin
        done_o = 1'b1;
        if (!enable_i) begin
          clr_sent = 1'b1;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sent_d     = sent_q;
    dest_idx_d = dest_idx_q;
    if (clr_sent) begin
      sent_d = '0;
    end else if (pkt_done) begin
      sent_d = sent_q + count_width_p'(1);
    end
    if (pkt_done) begin
      if (dest_idx_q == idx_w_lp'(num_dests_p - 1)) dest_idx_d = '0;
      else                                          dest_idx_d = dest_idx_q + idx_w_lp'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mode_q     <= 1'b0;
      seq_q      <= '0;
      dest_idx_q <= '0;
      sent_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      seq_q      <= seq_d;
      dest_idx_q <= dest_idx_d;
      sent_q     <= sent_d;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else begin
      if (enq) begin
        mem_q[wr_ptr_q] <= enq_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (deq) rd_ptr_q <= ~rd_ptr_q;
      case ({enq, deq})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_wormhole_traffic_gen.sv
module tb_bsg_wormhole_traffic_gen;

  logic        clk;
  logic        rst_n;
  logic [15:0] dest_x, dest_y;
  logic [3:0]  len;
  logic        mode;
  logic [15:0] num_pkts;
  logic        enable;
  logic        done;
  logic [15:0] sent;
  logic        rand_rdy;

  int total = 0;
  int bad   = 0;
  int xfer_cnt = 0;

  logic [3:0]  tbl_x [4] = '{4'hA, 4'hB, 4'hC, 4'hD};
  logic [3:0]  tbl_y [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
  int          m_dest = 0;
  logic [31:0] m_seq  = '0;
  logic [31:0] sb [$];

  logic        stall_pend = 1'b0;
  logic [31:0] stall_data;

  bsg_wormhole_traffic_gen_if #(.width_p(32)) link ();

  bsg_wormhole_traffic_gen dut (
    .clk_i          (clk),
    .reset_n_i      (rst_n),
    .dest_x_i       (dest_x),
    .dest_y_i       (dest_y),
    .len_i          (len),
    .mode_i         (mode),
    .num_packets_i  (num_pkts),
    .enable_i       (enable),
    .out_if         (link),
    .done_o         (done),
    .packets_sent_o (sent)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: header to the current table entry, then the body flits.
  task automatic push_packet(input int l, input logic md);
    sb.push_back({tbl_x[m_dest], tbl_y[m_dest], 4'(l), 20'h0});
    for (int c = l - 1; c >= 0; c--) begin
      if (md) begin
        sb.push_back(m_seq);
        m_seq = m_seq + 32'd1;
      end else begin
        sb.push_back(32'(c));
      end
    end
    m_dest = (m_dest + 1) % 4;
  endtask

  task automatic wait_done(input string tag, input int max);
    bit seen = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    if (!seen) chk({tag, "_done_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_drain(input string tag, input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    chk({tag, "_drain"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_xfers(input string tag, input int target, input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (xfer_cnt >= target) break;
    end
    if (xfer_cnt < target) chk({tag, "_xfer_timeout"}, 32'(xfer_cnt), 32'(target));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    sb.delete();
    m_dest = 0;
    m_seq  = '0;
  endtask

  task automatic finish_run(input string tag);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    chk({tag, "_sent_clr"}, 32'(sent), 32'd0);
    chk({tag, "_done_lo"}, 32'(done), 32'd0);
  endtask

  // Scoreboard monitor: compares every transfer and checks stall stability.
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst_n) begin
      if (link.valid_o && stall_pend) chk("stable", link.data_o, stall_data);
      if (link.valid_o && link.ready_i) begin
        xfer_cnt++;
        if (sb.size() == 0) begin
          chk("extra_flit", link.data_o, 32'hDEAD_BEEF);
        end else begin
          e = sb.pop_front();
          chk("flit", link.data_o, e);
        end
      end
      stall_pend = link.valid_o && !link.ready_i;
      stall_data = link.data_o;
    end else begin
      stall_pend = 1'b0;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) link.ready_i = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    rst_n       = 1'b0;
    dest_x      = {tbl_x[3], tbl_x[2], tbl_x[1], tbl_x[0]};
    dest_y      = {tbl_y[3], tbl_y[2], tbl_y[1], tbl_y[0]};
    len         = '0;
    mode        = 1'b0;
    num_pkts    = '0;
    enable      = 1'b0;
    rand_rdy    = 1'b0;
    link.ready_i = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(link.valid_o), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sent", 32'(sent), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single countdown packet with a budget of one.
    len = 4'd3; mode = 1'b0; num_pkts = 16'd1;
    push_packet(3, 1'b0);
    enable = 1'b1;
    wait_done("A", 100);
    wait_drain("A", 50);
    chk("A_sent", 32'(sent), 32'd1);
    chk("A_done", 32'(done), 32'd1);
    finish_run("A");

    // Header-only packets walk and wrap the destination table.
    pulse_reset();
    len = 4'd0; num_pkts = 16'd6;
    for (int i = 0; i < 6; i++) push_packet(0, 1'b0);
    enable = 1'b1;
    wait_done("B", 100);
    wait_drain("B", 50);
    chk("B_sent", 32'(sent), 32'd6);
    chk("B_done", 32'(done), 32'd1);
    finish_run("B");

    // Sequence payload continues across packets.
    pulse_reset();
    len = 4'd2; mode = 1'b1; num_pkts = 16'd3;
    for (int i = 0; i < 3; i++) push_packet(2, 1'b1);
    enable = 1'b1;
    wait_done("C", 100);
    wait_drain("C", 50);
    chk("C_sent", 32'(sent), 32'd3);
    chk("C_seq_model", m_seq, 32'd6);
    finish_run("C");

    // Random backpressure on long packets.
    len = 4'd15; mode = 1'b0; num_pkts = 16'd2;
    push_packet(15, 1'b0);
    push_packet(15, 1'b0);
    rand_rdy = 1'b1;
    enable = 1'b1;
    wait_done("D", 400);
    wait_drain("D", 400);
    rand_rdy = 1'b0;
    link.ready_i = 1'b1;
    chk("D_sent", 32'(sent), 32'd2);
    finish_run("D");

    // enable/len/mode changes mid-packet must not alter the packet.
    len = 4'd4; mode = 1'b0; num_pkts = 16'd0;
    push_packet(4, 1'b0);
    enable = 1'b1;
    wait_xfers("E", xfer_cnt + 1, 50);
    enable = 1'b0; len = 4'd7; mode = 1'b1;
    wait_drain("E", 50);
    repeat (5) @(negedge clk);
    chk("E_sent", 32'(sent), 32'd1);
    chk("E_done", 32'(done), 32'd0);
    chk("E_valid_idle", 32'(link.valid_o), 32'd0);

    // Asynchronous reset in the middle of a body.
    len = 4'd15; mode = 1'b0; num_pkts = 16'd0;
    push_packet(15, 1'b0);
    enable = 1'b1;
    wait_xfers("F", xfer_cnt + 4, 50);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("F_rst_valid", 32'(link.valid_o), 32'd0);
    chk("F_rst_done", 32'(done), 32'd0);
    chk("F_rst_sent", 32'(sent), 32'd0);
    enable = 1'b0;
    sb.delete();
    m_dest = 0;
    m_seq  = '0;
    #1 rst_n = 1'b1;
    len = 4'd1; num_pkts = 16'd1;
    push_packet(1, 1'b0);
    @(negedge clk);
    enable = 1'b1;
    wait_done("F", 100);
    wait_drain("F", 50);
    chk("F_sent", 32'(sent), 32'd1);
    finish_run("F");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
